// File: rtl/ppu_event_sched.sv
// ppu_event_sched
//
// Collects PPU timing edges (blanking / sync / burst) from eight edge
// detectors into per-source pending slots. Each slot keeps the timestamp of
// its oldest outstanding event. A round-robin arbiter drains the slots into a
// single registered valid/ready record stream, one record per cycle. Events
// that arrive while their slot is still occupied are dropped. The dropped
// event is flagged on that slot's next record and counted in a saturating
// global counter.
//
// Ports
//   clock            system clock
//   reset            synchronous, active-high reset
//   enable_i[7:0]    per-source capture enable
//   event_i[7:0]     single-cycle edge pulses
//                    0 vblank rise, 1 vblank fall, 2 hblank rise,
//                    3 hblank fall, 4 csync_n rise, 5 csync_n fall,
//                    6 burst_n rise, 7 burst_n fall
//   flush_i          discard pending slots, output record and overrun count
//   out_valid_o      record available
//   out_ready_i      consumer accepts the record while out_valid_o is high
//   out_source_o     source index of the record
//   out_timestamp_o  timestamp captured when the event arrived
//   out_lost_o       a later event on this source was dropped while the
//                    record waited in its slot
//   pending_o        pending slot flags
//   overrun_count_o  total dropped events, saturating at 255

module ppu_event_sched #(
    parameter int TS_WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          enable_i,
    input  logic [7:0]          event_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2:0]          out_source_o,
    output logic [TS_WIDTH-1:0] out_timestamp_o,
    output logic                out_lost_o,
    output logic [7:0]          pending_o,
    output logic [7:0]          overrun_count_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TS_WIDTH-1:0] r_ts;
    logic [2:0]          r_ptr;
    logic [7:0]          r_pending;
    logic [7:0]          r_lost;
    logic [TS_WIDTH-1:0] r_ts_cap [8];
    logic [7:0]          r_overrun;

    logic [2:0]          r_out_source;
    logic [TS_WIDTH-1:0] r_out_ts;
    logic                r_out_lost;

    logic [2:0]          w_win;
    logic                w_found;
    logic                w_can_load;
    logic                w_grant;
    logic [7:0]          w_gnt_vec;
    logic [7:0]          w_cap;
    logic [7:0]          w_drop;
    logic [7:0]          w_fresh;

    // Number of set bits in an 8-bit vector.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Saturating add of up to eight drops onto the 8-bit overrun count.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b00000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Round-robin scan starting at r_ptr. The index addition is 3 bits wide,
    // so it wraps modulo 8 on its own.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (!w_found && r_pending[r_ptr + 3'(j)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 3'(j);
            end
        end
    end

    // The output register can take a new record when it is empty, or when
    // the current record is being accepted in this same cycle.
    assign w_can_load = (r_state == ST_EMPTY) || out_ready_i;
    assign w_grant    = w_found && w_can_load && !flush_i;
    assign w_gnt_vec  = w_grant ? (8'b0000_0001 << w_win) : 8'b0000_0000;

    // A slot being granted this cycle counts as free. A coincident event
    // therefore recaptures that slot fresh and is not counted as a drop.
    assign w_cap   = event_i & enable_i;
    assign w_drop  = w_cap & r_pending & ~w_gnt_vec;
    assign w_fresh = w_cap & ~w_drop;

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_grant) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && out_ready_i) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts         <= '0;
            r_ptr        <= '0;
            r_pending    <= '0;
            r_lost       <= '0;
            r_overrun    <= '0;
            r_out_source <= '0;
            r_out_ts     <= '0;
            r_out_lost   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_ts_cap[i] <= '0;
            end
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (flush_i) begin
                // Flush leaves the timestamp counter and the arbiter
                // pointer running, so fairness carries across a flush.
                r_pending <= '0;
                r_lost    <= '0;
                r_overrun <= '0;
            end else begin
                r_pending <= (r_pending & ~w_gnt_vec) | w_cap;
                r_lost    <= (r_lost & ~w_gnt_vec & ~w_fresh) | w_drop;
                r_overrun <= sat_add8(r_overrun, popcount8(w_drop));
                for (int i = 0; i < 8; i++) begin
                    if (w_fresh[i]) begin
                        r_ts_cap[i] <= r_ts;
                    end
                end
                // The record takes the slot contents from before this edge.
                // A coincident recapture of the same slot is not visible here.
                if (w_grant) begin
                    r_out_source <= w_win;
                    r_out_ts     <= r_ts_cap[w_win];
                    r_out_lost   <= r_lost[w_win];
                    r_ptr        <= w_win + 3'd1;
                end
            end
        end
    end

    assign out_valid_o     = (r_state == ST_FULL);
    assign out_source_o    = r_out_source;
    assign out_timestamp_o = r_out_ts;
    assign out_lost_o      = r_out_lost;
    assign pending_o       = r_pending;
    assign overrun_count_o = r_overrun;

endmodule

// File: tb/tb_ppu_event_sched.sv
// Testbench for ppu_event_sched.
// Expected records are queued when stimulus is driven. A monitor pops and
// compares them on every accepted record. Inputs change 1 ns after the
// rising edge, and the monitor samples on the falling edge.

module tb_ppu_event_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  enable_i;
    logic [7:0]  event_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  out_source_o;
    logic [15:0] out_timestamp_o;
    logic        out_lost_o;
    logic [7:0]  pending_o;
    logic [7:0]  overrun_count_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  src;
        logic [15:0] ts;
        logic        lost;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;

    // Reference timestamp: equals the DUT's counter value during each cycle.
    logic [15:0] tb_ts;

    always #5 clock = ~clock;

    ppu_event_sched #(.TS_WIDTH(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable_i        (enable_i),
        .event_i         (event_i),
        .flush_i         (flush_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_source_o    (out_source_o),
        .out_timestamp_o (out_timestamp_o),
        .out_lost_o      (out_lost_o),
        .pending_o       (pending_o),
        .overrun_count_o (overrun_count_o)
    );

    always @(posedge clock) begin
        if (reset) tb_ts <= 16'd0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    // Scoreboard monitor: each accepted record must match the queue head.
    always @(negedge clock) begin
        if (!reset && out_valid_o && out_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rec_unexpected: got src=%0d ts=%0d lost=%0d, required no record",
                         out_source_o, out_timestamp_o, out_lost_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_source_o !== mon_e.src || out_timestamp_o !== mon_e.ts ||
                    out_lost_o !== mon_e.lost) begin
                    bad++;
                    $display("FAIL rec: got src=%0d ts=%0d lost=%0d, required src=%0d ts=%0d lost=%0d",
                             out_source_o, out_timestamp_o, out_lost_o,
                             mon_e.src, mon_e.ts, mon_e.lost);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_rec(input logic [2:0] s, input logic [15:0] t, input logic l);
        rec_t r;
        r.src  = s;
        r.ts   = t;
        r.lost = l;
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable_i    = 8'h00;
        event_i     = 8'h00;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        step();
        step();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_ts(input logic [15:0] target);
        int n = 0;
        while (tb_ts != target && n < 200) begin
            step();
            n++;
        end
        total++;
        if (tb_ts != target) begin
            bad++;
            $display("FAIL wait_ts: got ts=%0d, required %0d", tb_ts, target);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d records outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        enable_i    = 8'hFF;
        event_i     = 8'hFF;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        step();
        step();
        step();
        total++;
        if (out_valid_o !== 1'b0 || out_source_o !== 3'd0 || out_timestamp_o !== 16'd0 ||
            out_lost_o !== 1'b0 || pending_o !== 8'h00 || overrun_count_o !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: got v=%b s=%0d t=%0d l=%b p=%h o=%0d, required all zero",
                     out_valid_o, out_source_o, out_timestamp_o, out_lost_o,
                     pending_o, overrun_count_o);
        end
        event_i = 8'h00;
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_single();
        enable_i    = 8'hFF;
        out_ready_i = 1'b1;
        wait_ts(16'd5);
        event_i = 8'h01;
        push_rec(3'd0, 16'd5, 1'b0);
        step();
        event_i = 8'h00;
        total++;
        if (pending_o !== 8'h01 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_pending: got p=%h v=%b, required p=01 v=0", pending_o, out_valid_o);
        end
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_timestamp_o !== 16'd5) begin
            bad++;
            $display("FAIL single_valid: got v=%b t=%0d, required v=1 t=5", out_valid_o, out_timestamp_o);
        end
        step();
        total++;
        if (out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_oneshot: got v=%b, required 0", out_valid_o);
        end
        drain();
    endtask

    task automatic test_enable_mask();
        do_reset();
        enable_i    = 8'hFE;
        out_ready_i = 1'b1;
        event_i     = 8'h01;
        step();
        event_i = 8'h00;
        step();
        total++;
        if (pending_o !== 8'h00 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL enable_mask: got p=%h v=%b, required p=00 v=0", pending_o, out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] t;
        logic [7:0]  expp;
        do_reset();
        enable_i    = 8'hFF;
        out_ready_i = 1'b1;
        step();
        event_i = 8'hFF;
        t = tb_ts;
        for (int i = 0; i < 8; i++) push_rec(3'(i), t, 1'b0);
        step();
        event_i = 8'h00;
        for (int k = 0; k < 9; k++) begin
            expp = 8'hFF << k;
            total++;
            if (pending_o !== expp) begin
                bad++;
                $display("FAIL burst_pending[%0d]: got %h, required %h", k, pending_o, expp);
            end
            step();
        end
        drain();
    endtask

    task automatic test_held_drop();
        do_reset();
        enable_i    = 8'hFF;
        out_ready_i = 1'b0;
        wait_ts(16'd3);
        event_i = 8'h01;
        push_rec(3'd0, 16'd3, 1'b0);
        step();
        event_i = 8'h00;
        wait_ts(16'd10);
        event_i = 8'h04;
        push_rec(3'd2, 16'd10, 1'b1);
        step();
        event_i = 8'h00;
        wait_ts(16'd20);
        event_i = 8'h04;
        step();
        event_i = 8'h00;
        wait_ts(16'd30);
        event_i = 8'h04;
        step();
        event_i = 8'h00;
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_source_o !== 3'd0 || out_timestamp_o !== 16'd3) begin
            bad++;
            $display("FAIL held_record: got v=%b s=%0d t=%0d, required v=1 s=0 t=3",
                     out_valid_o, out_source_o, out_timestamp_o);
        end
        total++;
        if (pending_o !== 8'h04 || overrun_count_o !== 8'd2) begin
            bad++;
            $display("FAIL held_drops: got p=%h o=%0d, required p=04 o=2", pending_o, overrun_count_o);
        end
        out_ready_i = 1'b1;
        drain();
        total++;
        if (overrun_count_o !== 8'd2) begin
            bad++;
            $display("FAIL held_overrun_after: got %0d, required 2", overrun_count_o);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] t;
        do_reset();
        enable_i    = 8'hFF;
        out_ready_i = 1'b0;
        step();
        event_i = 8'h04;
        push_rec(3'd2, tb_ts, 1'b0);
        step();
        event_i = 8'h00;
        step();
        event_i = 8'h22;
        t = tb_ts;
        push_rec(3'd5, t, 1'b0);
        push_rec(3'd1, t, 1'b0);
        step();
        event_i = 8'h00;
        total++;
        if (pending_o !== 8'h22 || out_source_o !== 3'd2) begin
            bad++;
            $display("FAIL fair_setup: got p=%h s=%0d, required p=22 s=2", pending_o, out_source_o);
        end
        out_ready_i = 1'b1;
        drain();
    endtask

    task automatic test_same_cycle();
        logic [15:0] ta;
        logic [15:0] tb;
        do_reset();
        enable_i    = 8'hFF;
        out_ready_i = 1'b0;
        event_i     = 8'h01;
        push_rec(3'd0, tb_ts, 1'b0);
        step();
        event_i = 8'h00;
        step();
        event_i = 8'h10;
        ta = tb_ts;
        push_rec(3'd4, ta, 1'b0);
        step();
        event_i = 8'h00;
        step();
        out_ready_i = 1'b1;
        event_i     = 8'h10;
        tb = tb_ts;
        push_rec(3'd4, tb, 1'b0);
        step();
        event_i = 8'h00;
        total++;
        if (out_source_o !== 3'd4 || out_timestamp_o !== ta || out_lost_o !== 1'b0 ||
            pending_o !== 8'h10) begin
            bad++;
            $display("FAIL same_cycle_grant: got s=%0d t=%0d l=%b p=%h, required s=4 t=%0d l=0 p=10",
                     out_source_o, out_timestamp_o, out_lost_o, pending_o, ta);
        end
        drain();
        total++;
        if (overrun_count_o !== 8'd0) begin
            bad++;
            $display("FAIL same_cycle_overrun: got %0d, required 0", overrun_count_o);
        end
    endtask

    task automatic test_flush_saturate();
        do_reset();
        enable_i    = 8'hFF;
        out_ready_i = 1'b0;
        event_i     = 8'h01;
        step();
        event_i = 8'h0E;
        step();
        step();
        step();
        event_i = 8'h02;
        step();
        event_i = 8'h00;
        step();
        total++;
        if (out_valid_o !== 1'b1 || pending_o !== 8'h0E || overrun_count_o !== 8'd7) begin
            bad++;
            $display("FAIL flush_setup: got v=%b p=%h o=%0d, required v=1 p=0e o=7",
                     out_valid_o, pending_o, overrun_count_o);
        end
        flush_i = 1'b1;
        event_i = 8'h20;
        step();
        flush_i = 1'b0;
        event_i = 8'h00;
        total++;
        if (out_valid_o !== 1'b0 || pending_o !== 8'h00 || overrun_count_o !== 8'd0) begin
            bad++;
            $display("FAIL flush_clear: got v=%b p=%h o=%0d, required v=0 p=00 o=0",
                     out_valid_o, pending_o, overrun_count_o);
        end
        step();
        total++;
        if (pending_o !== 8'h00 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_event_dropped: got p=%h v=%b, required p=00 v=0", pending_o, out_valid_o);
        end
        event_i = 8'h01;
        step();
        event_i = 8'h02;
        step();
        for (int i = 1; i <= 300; i++) begin
            event_i = 8'h02;
            step();
            if (i == 100 || i == 255 || i == 300) begin
                total++;
                if (overrun_count_o !== ((i > 255) ? 8'd255 : 8'(i))) begin
                    bad++;
                    $display("FAIL overrun_sat[%0d]: got %0d, required %0d",
                             i, overrun_count_o, (i > 255) ? 255 : i);
                end
            end
        end
        event_i = 8'h00;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_enable_mask();
        test_back_to_back();
        test_held_drop();
        test_fairness();
        test_same_cycle();
        test_flush_saturate();
        do_reset();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_event_sched.md
# ppu_event_sched

Schedules PPU timing events (blanking/sync edges) for delivery to the host as timestamped records over a single valid/ready stream. Sits downstream of the PPU edge detectors: each of 8 sources latches into a per-source pending slot with its capture time, and a round-robin arbiter drains the slots one record per cycle. Lost events (re-trigger while pending) are flagged per record and counted globally.

## Interface
- TS_WIDTH, 16, width of free-running timestamp counter and record timestamp

- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable_i  in  8  per-source capture enable; bit order matches event_i
- event_i  in  8  single-cycle edge pulses; bit 0 vblank rise, 1 vblank fall, 2 hblank rise, 3 hblank fall, 4 csync_n rise, 5 csync_n fall, 6 burst_n rise, 7 burst_n fall
- flush_i  in  1  discard all pending slots, output record and overrun count
- out_valid_o  out  1  record available
- out_ready_i  in  1  consumer accepts record when high with out_valid_o
- out_source_o  out  3  source index of record
- out_timestamp_o  out  TS_WIDTH  timestamp captured at the event
- out_lost_o  out  1  at least one later event on this source dropped before this record left its slot
- pending_o  out  8  current pending slot flags
- overrun_count_o  out  8  total dropped events, saturates at 255

## Operation
- ts: free-running counter, +1 every cycle, wraps 2^TS_WIDTH-1 -> 0.
- Per-source state: pending[i], ts_cap[i], lost[i].
- Capture: event_i[i] & enable_i[i] with slot i free (or being granted this cycle) -> pending[i]=1, ts_cap[i]=ts (current-cycle value), lost[i]=0.
- Drop: event_i[i] & enable_i[i] with slot i pending and not granted this cycle -> lost[i]=1, ts_cap unchanged (oldest event kept), overrun_count+1 (saturating; stays 255).
- event_i[i] with enable_i[i]=0 ignored. Clearing enable_i[i] does not clear an existing pending slot.
- Output register: states EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
- Grant condition: any pending and (EMPTY, or FULL with out_ready_i=1).
- Arbiter: round-robin pointer ptr (3 bits). Winner = first i with pending[i] scanning ptr, ptr+1, ... mod 8. On grant of k: output register <= {k, ts_cap[k], lost[k]}, pending[k]=0, lost[k]=0, ptr=(k+1) mod 8, state FULL.
- FULL & out_ready_i & no pending -> EMPTY.
- FULL & !out_ready_i: output fields held stable; no grant.
- flush_i (priority below reset, above all else): pending, lost, overrun_count cleared; state EMPTY; event_i in the same cycle dropped. ts and ptr unaffected.

## Timing
- Reset: ts=0, ptr=0, pending/lost/ts_cap=0, state EMPTY; out_valid_o=0, out_source_o=0, out_timestamp_o=0, out_lost_o=0, pending_o=0, overrun_count_o=0.
- Event in cycle N -> pending_o[i]=1 in N+1 -> out_valid_o=1 in N+2 (EMPTY, no contention); out_timestamp_o = ts value during N.
- Sustained throughput one record per cycle while out_ready_i=1 and slots pending.
- Same-cycle event and grant on source k: granted record carries old ts_cap/lost; slot k recaptures fresh with lost=0, no overrun increment.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset then event_i=8'h01, enable_i=8'hFF at ts=5, out_ready_i=1 -> out_valid_o high two cycles later for one cycle, source 0, timestamp 5, lost 0.
- event_i=8'hFF in one cycle, out_ready_i=1 -> eight consecutive records, sources 0..7 in order, identical timestamps; pending_o drains one bit per cycle.
- out_ready_i=0, source 2 fires at ts=10, 20, 30 -> record held; when ready raised: source 2, timestamp 10, lost 1; overrun_count_o=2.
- Pointer fairness: ptr=3 after granting source 2, sources 1 and 5 pending -> 5 granted before 1.
- Event on source 4 in the exact handshake cycle of a pending source-4 grant -> granted record unchanged, next source-4 record lost=0 with new timestamp, overrun_count_o unchanged.
- flush_i while FULL with 3 pending and overrun_count_o=7 -> next cycle out_valid_o=0, pending_o=0, overrun_count_o=0; coincident event dropped; 300 drops -> count saturates at 255.
